// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, ID-width helper and header tag default for uart_tx_arbiter
package uart_arb_pkg;

  // IDLE -> (HDR when UART_ARB_HDR_EN) -> SEND -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } arb_state_e;

  // Base value of the per-grant header byte; the grant index is OR-ed into the low bits
  localparam logic [7:0] DEF_HDR_TAG = 8'hA0;

  // Width of a requester index; never below one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit after ptr, wrapping modulo N
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Search ptr+1, ptr+2, ... ptr+N; ptr itself is checked last so the previous owner yields
  always_comb begin
    int cand;
    logic [W-1:0] cw;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    cw    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      cw   = W'(cand);
      if (!found && req[cw]) begin
        found = 1'b1;
        idx   = cw;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin sharing of the UART TX FIFO write port (UART_ARB_HDR_EN adds a header byte per grant)
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int              N_REQ     = 4,
  parameter int              DBIT      = 8,
  parameter int              MAX_BURST = 16,
  parameter logic [DBIT-1:0] HDR_TAG   = DBIT'(DEF_HDR_TAG),
  localparam int             GW        = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DBIT-1:0]   req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DBIT-1:0]         w_data,
  output logic                    wr_uart,
  input  logic                    tx_full,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           pick_found;
  logic [GW-1:0]  pick_idx;

  logic           g_valid;
  logic           g_last;
  logic [DBIT-1:0] g_data;

  rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the granted requester's lane (valid, last, data)
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DBIT +: DBIT];
      end
    end
  end

  // Arbitration state, grant owner, burst count and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus the same-cycle FIFO write path; the owner is released on last or a full burst
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
`ifdef UART_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_SEND;
`endif
        end
      end
      ST_HDR: begin
        wr_uart = !tx_full;
        w_data  = HDR_TAG | DBIT'(grant_q);
        if (!tx_full) state_d = ST_SEND;
      end
      ST_SEND: begin
        for (int i = 0; i < N_REQ; i++) begin
          req_ready[i] = (grant_q == GW'(i)) && !tx_full;
        end
        if (g_valid && !tx_full) begin
          wr_uart = 1'b1;
          w_data  = g_data;
          cnt_d   = cnt_q + 8'd1;
          if (g_last || (cnt_d == BURST_MAX)) begin
            ptr_d   = grant_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
